// File: rtl/quotient_reconstructor.sv
// quotient_reconstructor: rebuilds dividend = quotient*divisor + remainder by serial shift-add, one quotient bit per cycle.
// Optional self-check comparator enabled by defining RECON_CHECK_EN.
module quotient_reconstructor (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  quotient,
    input  logic [19:0] divisor,
    input  logic [19:0] remainder,
`ifdef RECON_CHECK_EN
    input  logic [27:0] dividend_ref,
    output logic        mismatch,
`endif
    output logic        busy,
    output logic        done,
    output logic [27:0] dividend
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  quo_q, quo_d;
    logic [19:0] div_q, div_d;
    logic [19:0] rem_q, rem_d;
    logic [27:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [27:0] dividend_q, dividend_d;
    logic [27:0] sum;
    assign sum = acc_q + (quo_q[cnt_q] ? ({8'd0, div_q} << cnt_q) : 28'd0);
`ifdef RECON_CHECK_EN
    logic [27:0] ref_q, ref_d;
    logic        mismatch_q, mismatch_d;
    always_comb begin
        ref_d      = (state_q == IDLE && start) ? dividend_ref : ref_q;
        mismatch_d = (state_q == BUSY && cnt_q == 3'd7) ? ((sum != ref_q) || (rem_q >= div_q)) : mismatch_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            ref_q      <= ref_d;
            mismatch_q <= mismatch_d;
        end
    end
    assign mismatch = mismatch_q;
`endif
    always_comb begin
        state_d    = state_q;
        quo_d      = quo_q;
        div_d      = div_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        case (state_q)
            IDLE: if (start) begin
                quo_d   = quotient;
                div_d   = divisor;
                rem_d   = remainder;
                acc_d   = {8'd0, remainder};
                cnt_d   = 3'd0;
                state_d = BUSY;
            end
            BUSY: begin
                acc_d = sum;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    dividend_d = sum;
                    state_d    = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            quo_q      <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            dividend_q <= '0;
        end else begin
            state_q    <= state_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
        end
    end
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign dividend = dividend_q;
endmodule

// File: tb/tb_quotient_reconstructor.sv
// tb_quotient_reconstructor: scoreboard bench; expected dividends are queued at start and popped on each done.
module tb_quotient_reconstructor;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  quotient = '0;
    logic [19:0] divisor = '0;
    logic [19:0] remainder = '0;
    logic        busy, done;
    logic [27:0] dividend;
    int          checks = 0;
    int          errors = 0;
    logic [27:0] sb[$];
`ifdef RECON_CHECK_EN
    logic [27:0] dividend_ref = '0;
    logic        mismatch;
`endif

    quotient_reconstructor dut (
        .clock(clock), .reset(reset), .start(start),
        .quotient(quotient), .divisor(divisor), .remainder(remainder),
`ifdef RECON_CHECK_EN
        .dividend_ref(dividend_ref), .mismatch(mismatch),
`endif
        .busy(busy), .done(done), .dividend(dividend)
    );

    always #5 clock = ~clock;

    function automatic logic [27:0] model(input logic [7:0] q, input logic [19:0] d, input logic [19:0] r);
        return {20'd0, q} * {8'd0, d} + {8'd0, r};
    endfunction

    always @(negedge clock) begin
        if (done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done dividend=%h with empty scoreboard", dividend);
            end else begin
                logic [27:0] exp;
                exp = sb.pop_front();
                if (dividend !== exp) begin
                    errors++;
                    $display("FAIL dividend got %h want %h", dividend, exp);
                end
            end
        end
    end

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, dividend} !== 30'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b dividend=%h want 0 0 0", busy, done, dividend);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int n, b;
        start = 1'b1; quotient = 8'h05; divisor = 20'h00003; remainder = 20'h00001;
        sb.push_back(model(8'h05, 20'h00003, 20'h00001));
        n = 0; b = 0;
        do begin
            @(negedge clock);
            start = 1'b0;
            n++;
            if (busy) b++;
        end while (!done && n < 20);
        checks++;
        if (n !== 9) begin errors++; $display("FAIL latency got %0d want 9", n); end
        checks++;
        if (b !== 9) begin errors++; $display("FAIL busy_cycles got %0d want 9", b); end
        checks++;
        if (dividend !== 28'h0000010) begin errors++; $display("FAIL basic_value got %h want 0000010", dividend); end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_done got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_max_hold;
        int n;
        start = 1'b1; quotient = 8'hFF; divisor = 20'hFFFFF; remainder = 20'hFFFFF;
        sb.push_back(28'hFFFFF00);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            start = 1'b0;
            checks++;
            if (dividend !== 28'h0000010 || done !== 1'b0) begin
                errors++;
                $display("FAIL hold_during_busy cycle %0d got dividend=%h done=%b want 0000010 0", i, dividend, done);
            end
        end
        n = 0;
        while (!done && n < 5) begin @(negedge clock); n++; end
        checks++;
        if (n !== 1) begin errors++; $display("FAIL max_latency got extra %0d want 1", n); end
        repeat (2) @(negedge clock);
        checks++;
        if (dividend !== 28'hFFFFF00) begin errors++; $display("FAIL hold_after_done got %h want FFFFF00", dividend); end
    endtask

    task automatic test_back_to_back;
        int n, k;
        int t[3];
        start = 1'b1; quotient = 8'hA5; divisor = 20'h12345; remainder = 20'h00ABC;
        repeat (3) sb.push_back(model(8'hA5, 20'h12345, 20'h00ABC));
        n = 0; k = 0;
        while (k < 3 && n < 40) begin
            @(negedge clock);
            n++;
            if (done) begin t[k] = n; k++; end
        end
        start = 1'b0;
        checks++;
        if (k !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", k); end
        else begin
            checks++;
            if (t[0] !== 9) begin errors++; $display("FAIL b2b_first got %0d want 9", t[0]); end
            checks++;
            if (t[1] - t[0] !== 10) begin errors++; $display("FAIL b2b_period1 got %0d want 10", t[1] - t[0]); end
            checks++;
            if (t[2] - t[1] !== 10) begin errors++; $display("FAIL b2b_period2 got %0d want 10", t[2] - t[1]); end
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_ignore_start;
        int n;
        start = 1'b1; quotient = 8'h3C; divisor = 20'h0F0F0; remainder = 20'h00123;
        sb.push_back(model(8'h3C, 20'h0F0F0, 20'h00123));
        n = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clock);
            n++;
            start = i[0];
            quotient = 8'($urandom);
            divisor = 20'($urandom);
            remainder = 20'($urandom);
        end
        @(negedge clock);
        n++;
        start = 1'b0;
        while (!done && n < 20) begin @(negedge clock); n++; end
        checks++;
        if (n !== 9) begin errors++; $display("FAIL ignore_latency got %0d want 9", n); end
        repeat (15) @(negedge clock);
    endtask

    task automatic test_reset_abort;
        int n;
        start = 1'b1; quotient = 8'h12; divisor = 20'h00010; remainder = 20'h00005;
        repeat (4) begin @(negedge clock); start = 1'b0; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_precondition busy got %b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, dividend} !== 30'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b dividend=%h want 0 0 0", busy, done, dividend);
        end
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        repeat (12) begin @(negedge clock); if (done) n++; end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL aborted_done got %0d pulses want 0", n); end
        start = 1'b1; quotient = 8'h02; divisor = 20'h00007; remainder = 20'h00000;
        sb.push_back(28'h000000E);
        n = 0;
        do begin @(negedge clock); start = 1'b0; n++; end while (!done && n < 20);
        checks++;
        if (dividend !== 28'h000000E) begin errors++; $display("FAIL post_reset_value got %h want 000000E", dividend); end
        repeat (2) @(negedge clock);
    endtask

`ifdef RECON_CHECK_EN
    task automatic test_check;
        logic [19:0] rs[3] = '{20'h00005, 20'h00005, 20'h00010};
        logic [27:0] refs[3] = '{28'h0000125, 28'h0000124, 28'h0000130};
        logic        mm[3] = '{1'b0, 1'b1, 1'b1};
        int n;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; quotient = 8'h12; divisor = 20'h00010; remainder = rs[i]; dividend_ref = refs[i];
            sb.push_back(model(8'h12, 20'h00010, rs[i]));
            n = 0;
            do begin @(negedge clock); start = 1'b0; n++; end while (!done && n < 20);
            checks++;
            if (mismatch !== mm[i]) begin errors++; $display("FAIL mismatch case %0d got %b want %b", i, mismatch, mm[i]); end
            @(negedge clock);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_max_hold();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
`ifdef RECON_CHECK_EN
        test_check();
`endif
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/quotient_reconstructor.md
QUOTIENT_RECONSTRUCTOR -- requirements
Module: quotient_reconstructor

Interface
REQ-001 Parameters: none; all widths SHALL be fixed to match the divider datapath (28-bit dividend, 20-bit divisor, 8-bit quotient).
REQ-002 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 quotient  input  8  quotient bits from the divider, bit 7 = MSB.
REQ-006 divisor  input  20  divisor paired with the quotient.
REQ-007 remainder  input  20  final remainder, unsigned.
REQ-008 busy  output  1  high in BUSY and DONE.
REQ-009 done  output  1  one-cycle pulse; dividend valid.
REQ-010 dividend  output  28  reconstructed value quotient*divisor + remainder.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY and DONE; reset SHALL enter IDLE.
REQ-012 IDLE with start=1 at an edge SHALL capture quotient/divisor/remainder, load acc = zero-extended remainder (28 b), clear bit counter, and go to BUSY.
REQ-013 BUSY SHALL process one quotient bit per cycle, LSB first: acc = acc + (q[i] ? divisor << i : 0), with i = counter 0..7.
REQ-014 After the 8th BUSY edge the FSM SHALL enter DONE, register acc into dividend, and drive done=1 for exactly that one cycle.
REQ-015 Latency SHALL be fixed: done is high in the 9th cycle after the start-accepting edge, independent of operand values.
REQ-016 DONE SHALL return to IDLE on the next edge unconditionally; back-to-back operation SHALL therefore take 10 cycles per item.
REQ-017 start while busy=1 SHALL be ignored, with no queuing and no effect on captured operands.
REQ-018 The arithmetic SHALL be unsigned 28-bit; the maximum (0xFF*0xFFFFF + 0xFFFFF = 0xFFFFF00) fits, so there is no overflow output.
REQ-019 dividend SHALL hold its last value from DONE until the next DONE; it SHALL NOT change during BUSY.
REQ-020 Input changes after the accepting edge SHALL NOT affect the result.

Reset
REQ-021 reset=1 SHALL immediately force IDLE, busy=0, done=0, dividend=0, clearing acc, counter and captured operands, without waiting for a clock edge.
REQ-022 Reset asserted mid-BUSY SHALL abort the operation; no done pulse SHALL be produced for the aborted item.
REQ-023 The first start SHALL be accepted on the first rising edge with reset=0.

Configuration
REQ-024 Macro RECON_CHECK_EN: when defined, the block SHALL add input dividend_ref[27:0] (captured with the other operands) and output mismatch (1 bit, reset 0).
REQ-025 With RECON_CHECK_EN defined, mismatch SHALL be registered at the DONE transition and be valid with done; it is high if dividend != dividend_ref or if remainder >= divisor (including divisor=0).
REQ-026 With RECON_CHECK_EN defined, mismatch SHALL hold like dividend.
REQ-027 With RECON_CHECK_EN undefined, neither port SHALL exist and there SHALL be no comparator logic.

Verification
REQ-028 q=0x05, d=0x00003, r=0x00001, start pulse -> done 9 cycles later, dividend=0x0000010, busy high for 9 cycles.
REQ-029 q=0xFF, d=0xFFFFF, r=0xFFFFF -> dividend=0xFFFFF00.
REQ-030 start held high continuously with constant operands -> done pulses every 10 cycles; start pulses during BUSY produce no extra done.
REQ-031 reset asserted on the 4th BUSY cycle -> outputs 0 asynchronously, no done; a new op after reset with q=0x02, d=0x00007, r=0 -> dividend=0x000000E.
REQ-032 RECON_CHECK_EN: q=0x12, d=0x00010, r=0x00005, ref=0x0000125 -> mismatch=0; same operands with ref=0x0000124 -> mismatch=1; r=0x00010 (r >= d) -> mismatch=1.
